// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: access-size
// encodings, FSM states and the alignment rule.
package dmem_pkg;

  localparam int DMEM_AW_DEF = 11;

  typedef enum logic [1:0] {
    TYPE_WORD = 2'b00,
    TYPE_HALF = 2'b01,
    TYPE_BYTE = 2'b10,
    TYPE_RSVD = 2'b11
  } access_t;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_t;

  // A word must sit on lane 0, a half on an even lane, a byte anywhere.
  function automatic logic is_legal(access_t t, logic [1:0] lane);
    case (t)
      TYPE_WORD: is_legal = (lane == 2'b00);
      TYPE_HALF: is_legal = !lane[0];
      TYPE_BYTE: is_legal = 1'b1;
      default:   is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// MEM-stage request/response bundle between the pipeline (master) and the
// data-memory responder (slave).
interface dmem_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [1:0]  type_i;
  logic        sext_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        misalign_o;

  modport master (
    output req_i, we_i, addr_i, type_i, sext_i, wdata_i,
    input  ready_o, rvalid_o, rdata_o, misalign_o
  );

  modport slave (
    input  req_i, we_i, addr_i, type_i, sext_i, wdata_i,
    output ready_o, rvalid_o, rdata_o, misalign_o
  );
endinterface

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: extracts and extends load data from a RAM word,
// and merges sub-word store data into an existing word.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [31:0] ld_word_i,
  input  logic [1:0]  ld_lane_i,
  input  access_t     ld_type_i,
  input  logic        ld_sext_i,
  output logic [31:0] ld_data_o,

  input  logic [31:0] st_old_i,
  input  logic [31:0] st_data_i,
  input  logic [1:0]  st_lane_i,
  input  access_t     st_type_i,
  output logic [31:0] st_word_o,
  output logic        st_legal_o
);

  logic [15:0] ld_half;
  logic [7:0]  ld_byte;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    ld_half   = ld_lane_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    ld_byte   = ld_word_i[{ld_lane_i, 3'b000} +: 8];
    ld_data_o = '0;
    case (ld_type_i)
      TYPE_WORD: ld_data_o = ld_word_i;
      TYPE_HALF: ld_data_o = {{16{ld_sext_i & ld_half[15]}}, ld_half};
      TYPE_BYTE: ld_data_o = {{24{ld_sext_i & ld_byte[7]}}, ld_byte};
      default:   ld_data_o = '0;
    endcase
  end

  always_comb begin
    st_word_o = st_old_i;
    case (st_type_i)
      TYPE_WORD: st_word_o = st_data_i;
      TYPE_HALF: begin
        if (st_lane_i[1]) st_word_o[31:16] = st_data_i[15:0];
        else              st_word_o[15:0]  = st_data_i[15:0];
      end
      TYPE_BYTE: st_word_o[{st_lane_i, 3'b000} +: 8] = st_data_i[7:0];
      default:   st_word_o = st_old_i;
    endcase
    st_legal_o = is_legal(st_type_i, st_lane_i);
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word-wide synchronous RAM with single-cycle loads and
// word stores, and a two-state read-modify-write path for byte/half stores.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DMEM_AW = DMEM_AW_DEF
) (
  input  logic   clk_i,
  input  logic   rst_i,
  dmem_if.slave  bus
);

  localparam int DEPTH = 1 << DMEM_AW;

  logic [31:0] mem [DEPTH];
  logic [31:0] ram_rdata_q;

  state_t             state_q, state_d;
  logic [DMEM_AW-1:0] idx_q, idx_d;
  logic [1:0]         lane_q, lane_d;
  access_t            type_q, type_d;
  logic               sext_q, sext_d;
  logic [31:0]        data_q, data_d;
  logic               load_pend_q, load_pend_d;
  logic               misalign_q, misalign_d;
  logic [31:0]        hold_q, hold_d;

  logic               accept;
  logic               legal;
  access_t            req_type;
  logic [DMEM_AW-1:0] req_idx;
  logic               mem_we;
  logic               mem_re;
  logic [DMEM_AW-1:0] mem_widx;
  logic [31:0]        mem_wdata;
  logic [31:0]        ld_result;
  logic [31:0]        merge_word;
  logic [1:0]         st_lane;
  access_t            st_type;
  logic [31:0]        st_data;

  // Address bits above the word index wrap and are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^bus.addr_i[31:DMEM_AW+2];

  assign req_type = access_t'(bus.type_i);
  assign req_idx  = bus.addr_i[DMEM_AW+1:2];

  assign bus.ready_o  = (state_q == IDLE) && !rst_i;
  assign accept       = bus.req_i && bus.ready_o;
  assign bus.rvalid_o = load_pend_q;
  assign bus.misalign_o = misalign_q;
  assign bus.rdata_o  = load_pend_q ? ld_result : hold_q;

  // In IDLE the store port checks the incoming request; in MERGE it merges
  // the latched sub-word data into the word read on the accepting edge.
  assign st_lane = (state_q == MERGE) ? lane_q : bus.addr_i[1:0];
  assign st_type = (state_q == MERGE) ? type_q : req_type;
  assign st_data = (state_q == MERGE) ? data_q : bus.wdata_i;

  dmem_lane_unit u_lane (
    .ld_word_i  (ram_rdata_q),
    .ld_lane_i  (lane_q),
    .ld_type_i  (type_q),
    .ld_sext_i  (sext_q),
    .ld_data_o  (ld_result),
    .st_old_i   (ram_rdata_q),
    .st_data_i  (st_data),
    .st_lane_i  (st_lane),
    .st_type_i  (st_type),
    .st_word_o  (merge_word),
    .st_legal_o (legal)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    type_d      = type_q;
    sext_d      = sext_q;
    data_d      = data_q;
    load_pend_d = 1'b0;
    misalign_d  = 1'b0;
    hold_d      = bus.rdata_o;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_widx    = req_idx;
    mem_wdata   = bus.wdata_i;

    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d  = req_idx;
          lane_d = bus.addr_i[1:0];
          type_d = req_type;
          sext_d = bus.sext_i;
          data_d = bus.wdata_i;
          if (!legal) begin
            misalign_d = 1'b1;
          end else if (!bus.we_i) begin
            mem_re      = 1'b1;
            load_pend_d = 1'b1;
          end else if (req_type == TYPE_WORD) begin
            mem_we = 1'b1;
          end else begin
            mem_re  = 1'b1;
            state_d = MERGE;
          end
        end
      end
      MERGE: begin
        mem_we    = 1'b1;
        mem_widx  = idx_q;
        mem_wdata = merge_word;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A reset landing in MERGE drops the pending write.
    if (rst_i) mem_we = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      load_pend_q <= 1'b0;
      misalign_q  <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      load_pend_q <= load_pend_d;
      misalign_q  <= misalign_d;
      hold_q      <= hold_d;
    end
  end

  always_ff @(posedge clk_i) begin
    idx_q  <= idx_d;
    lane_q <= lane_d;
    type_q <= type_d;
    sext_q <= sext_d;
    data_q <= data_d;
  end

  // NOTE: the RAM array and its read register carry no reset so the array
  // maps onto block RAM; contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
    if (mem_re) ram_rdata_q <= mem[req_idx];
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the MEM-stage request interface: accepts load/store requests with byte address, access type and store data.
- Returns aligned, extended load data; performs byte/halfword stores by read-modify-write over a word-wide synchronous RAM.
- Exposes a ready/valid handshake so the pipeline can stall during sub-word stores.

Parameters:
- DMEM_AW, 11, word-index width; memory depth is 2^DMEM_AW 32-bit words.

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous reset, active-high
- req_i  input  1  request valid
- we_i  input  1  1 = store, 0 = load
- addr_i  input  32  byte address
- type_i  input  2  access size: 00 word, 01 half, 10 byte, 11 reserved
- sext_i  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- wdata_i  input  32  store data; sub-word data taken from the low bits
- ready_o  output  1  responder can accept a request this cycle
- rvalid_o  output  1  one-cycle pulse: rdata_o carries load result
- rdata_o  output  32  load result; holds value until the next load completes
- misalign_o  output  1  one-cycle pulse: previous accepted request was rejected

Behaviour:
- Interface:
  - Single clock clk_i.
  - rst_i is synchronous and active-high.
- Reset:
  - In the reset cycle: ready_o=0, rvalid_o=0, rdata_o=0, misalign_o=0, state=IDLE.
  - ready_o=1 from the first cycle after rst_i deasserts.
  - RAM contents are not cleared.
- Acceptance and addressing:
  - A request is accepted when req_i && ready_o at the clock edge.
  - req_i while ready_o=0 is ignored; the initiator holds the request.
  - Word index = addr_i[DMEM_AW+1:2]. Upper address bits are ignored (address wraps modulo depth).
  - Lane = addr_i[1:0], little-endian: byte 0 is bits [7:0].
- Legality:
  - Word requires lane=00; half requires addr_i[0]=0; byte is always legal; type 11 is always illegal.
  - Illegal request: accepted, no RAM change, no rvalid_o. misalign_o=1 in cycle N+1.
- Load accepted in cycle N:
  - In cycle N+1: rvalid_o=1 and rdata_o = selected lane, extended per sext_i (half uses bits [15:0] or [31:16]).
  - ready_o stays 1, so back-to-back loads run at one per cycle.
- Word store accepted in cycle N:
  - RAM written at the end of cycle N; ready_o stays 1.
- Sub-word store:
  - FSM states: IDLE, MERGE.
  - IDLE: a legal byte/half store in cycle N latches index, lane, type and data, issues a RAM read, and moves to MERGE.
  - MERGE (cycle N+1): ready_o=0. The read word is merged with the latched bytes, the RAM is written, and the state returns to IDLE. ready_o=1 in cycle N+2.
  - Net effect: one stall cycle per sub-word store.
- Ordering:
  - A load in the cycle after any store to the same word returns the post-store value. This requires write-first or bypass from the MERGE write.
  - Two sub-word stores back-to-back to the same word: the second merge sees the first's result.
- Reset mid-MERGE: the pending write is discarded (RAM word unchanged) and the FSM returns to IDLE.
- Priority: rst_i overrides every other input.

Decomposition:
- Package dmem_pkg:
  - Access-type encodings: TYPE_WORD=2'b00, TYPE_HALF=2'b01, TYPE_BYTE=2'b10, TYPE_RSVD=2'b11.
  - FSM state enum IDLE/MERGE.
  - Default DMEM_AW.
- One sub-module, dmem_lane_unit (purely combinational):
  - Load extract/extend: word, lane, type, sext -> result.
  - Store merge: old word, new data, lane, type -> merged word plus legality flag.
- RAM array and FSM live in dmem_responder.

Test Plan:
- Reset then load word at 0x0 after preload 0x11223344 -> cycle N+1 rvalid_o=1, rdata_o=0x11223344; ready_o=1 throughout.
- Byte store 0xAB at addr 0x6 onto word 1 = 0x11223344 -> ready_o=0 for exactly one cycle; a following word load at 0x4 returns 0x11AB3344.
- Half load at 0x2, word=0x8001FFFF: sext_i=1 -> 0xFFFF8001; sext_i=0 -> 0x00008001. Byte load at 0x3 with sext_i=1 -> 0xFFFFFF80.
- Word store at 0x5 -> misalign_o=1 next cycle, no rvalid_o, memory unchanged. Same for type 11 at 0x0, and for a half load at 0x1.
- Back-to-back: byte store 0x01 at 0x8, then byte store 0x02 at 0x9 held until ready -> word 2 low half reads 0x0201. An immediately following load returns the new value.
- Byte store 0xFF at 0xC with rst_i asserted in the MERGE cycle -> word 3 unchanged, ready_o=0 during reset then 1, no rvalid_o or misalign_o.
- Address 0x0000_2000 with DMEM_AW=11 -> aliases to word 0.
